// File: rtl/system_0_sysid_pkg.sv
// Shared types and constants for the sysid checker: FSM states, slave word
// addresses and the stall-counter width.
package system_0_sysid_pkg;

  localparam int STALL_W = 16;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    RD_TS,
    FINISH,
    FAIL
  } sysid_state_t;

endpackage

// File: rtl/system_0_sysid_stall_timer.sv
// Counts waitrequest stalls of the current read and flags a stall that has
// already lasted TIMEOUT_CYCLES cycles.
module system_0_sysid_stall_timer
  import system_0_sysid_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  localparam logic [STALL_W-1:0] LIMIT = STALL_W'(TIMEOUT_CYCLES);

  logic [STALL_W-1:0] count_reg;

  assign expired = stall && (count_reg == LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (stall && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/system_0_sysid_checker.sv
// Reads the system ID (and, with SYSID_CHECK_TIMESTAMP_EN defined, the
// timestamp) from an Avalon-MM sysid slave and compares them with expected values.
module system_0_sysid_checker
  import system_0_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1763570452,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  sysid_state_t state_reg, state_next;
  logic         boot_reg;
  logic         id_ok_reg, ts_ok_reg;
  logic [31:0]  id_value_reg;
  logic         reading, rd_done, stall, stall_clear, expired;
  logic         start_take, finish_cap, id_match, ts_match;

  assign reading     = (state_reg == RD_ID) || (state_reg == RD_TS);
  assign rd_done     = reading && !avm_waitrequest;
  assign stall       = reading && avm_waitrequest;
  assign stall_clear = !reading || rd_done;
  assign start_take  = !reading && (state_next == RD_ID);

  system_0_sysid_stall_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_stall_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (stall_clear),
    .stall  (stall),
    .expired(expired)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (start || boot_reg) state_next = RD_ID;
      RD_ID: begin
        if (!avm_waitrequest) begin
`ifdef SYSID_CHECK_TIMESTAMP_EN
          state_next = RD_TS;
`else
          state_next = FINISH;
`endif
        end else if (expired) begin
          state_next = FAIL;
        end
      end
      RD_TS: begin
        if (!avm_waitrequest)  state_next = FINISH;
        else if (expired)      state_next = FAIL;
      end
      FINISH: if (start) state_next = RD_ID;
      FAIL:   if (start) state_next = RD_ID;
      default: state_next = IDLE;
    endcase
  end

`ifdef SYSID_CHECK_TIMESTAMP_EN
  logic [31:0] ts_value_reg;

  // The ID was captured one read earlier, so compare the stored copy.
  assign finish_cap = (state_reg == RD_TS) && rd_done;
  assign id_match   = (id_value_reg == EXPECTED_ID);
  assign ts_match   = (avm_readdata == EXPECTED_TS);
  assign ts_value   = ts_value_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_value_reg <= '0;
    end else if (finish_cap) begin
      ts_value_reg <= avm_readdata;
    end
  end
`else
  assign finish_cap = (state_reg == RD_ID) && rd_done;
  assign id_match   = (avm_readdata == EXPECTED_ID);
  assign ts_match   = 1'b1;
  assign ts_value   = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      boot_reg     <= 1'b1;
      id_value_reg <= '0;
      id_ok_reg    <= 1'b0;
      ts_ok_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      boot_reg  <= 1'b0;
      if ((state_reg == RD_ID) && rd_done) id_value_reg <= avm_readdata;
      if (start_take) begin
        id_ok_reg <= 1'b0;
        ts_ok_reg <= 1'b0;
      end else if (finish_cap) begin
        id_ok_reg <= id_match;
        ts_ok_reg <= ts_match;
      end
    end
  end

  assign busy        = reading;
  assign avm_read    = reading;
  assign avm_address = (state_reg == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign done        = (state_reg == FINISH) || (state_reg == FAIL);
  assign timeout     = (state_reg == FAIL);
  assign id_ok       = id_ok_reg;
  assign ts_ok       = ts_ok_reg;
  assign id_value    = id_value_reg;

endmodule

// File: doc/system_0_sysid_checker.md
SYSTEM_0_SYSID_CHECKER -- requirements
Module: system_0_sysid_checker

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  EXPECTED_ID, 32'h0000_0000, system ID word expected at address 0.
  EXPECTED_TS, 32'd1763570452, timestamp word expected at address 1.
  TIMEOUT_CYCLES, 255, maximum cycles one read may stall on waitrequest (1..65535).
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clock  in  1  sole clock, rising edge.
  reset  in  1  asynchronous, active-high reset.
  start  in  1  single-cycle pulse that re-runs the check.
  avm_address  out  1  Avalon-MM master address into the sysid slave.
  avm_read  out  1  Avalon-MM read strobe.
  avm_readdata  in  32  slave read data.
  avm_waitrequest  in  1  slave stall.
  busy  out  1  check in progress.
  done  out  1  check finished (sticky until the next start).
  id_ok  out  1  captured ID equals EXPECTED_ID.
  ts_ok  out  1  captured timestamp equals EXPECTED_TS.
  timeout  out  1  a read exceeded TIMEOUT_CYCLES.
  id_value  out  32  last captured ID word.
  ts_value  out  32  last captured timestamp word.

Function
REQ-003 The FSM SHALL have exactly the states IDLE, RD_ID, RD_TS, FINISH and FAIL.
REQ-004 On reset deassertion the block SHALL enter RD_ID automatically on the first clock edge, without needing start.
REQ-005 IDLE, FINISH and FAIL SHALL move to RD_ID when start=1; in RD_ID and RD_TS, start SHALL be ignored.
REQ-006 In RD_ID, avm_read SHALL be 1 and avm_address SHALL be 0.
REQ-007 In RD_TS, avm_read SHALL be 1 and avm_address SHALL be 1.
REQ-008 avm_address and avm_read SHALL be held stable while avm_waitrequest=1.
REQ-009 A read SHALL complete in the cycle where avm_read=1 and avm_waitrequest=0. Read latency is zero: data SHALL be sampled in that same cycle.
REQ-010 On completion in RD_ID, avm_readdata SHALL be captured into id_value and the FSM SHALL go to RD_TS.
REQ-011 On completion in RD_TS, avm_readdata SHALL be captured into ts_value and the FSM SHALL go to FINISH.
REQ-012 A 16-bit stall counter SHALL clear on entry to each read state and SHALL increment on each cycle with waitrequest=1.
REQ-013 When the stall counter reaches TIMEOUT_CYCLES with waitrequest still 1, the FSM SHALL go to FAIL.
REQ-014 In FAIL, timeout=1, done=1, id_ok=0 and ts_ok=0.
REQ-015 The FSM SHALL leave FAIL only on start.
REQ-016 id_ok and ts_ok SHALL be registered comparisons, valid from the first FINISH cycle and held until the next start.
REQ-017 busy SHALL be 1 exactly in RD_ID and RD_TS.
REQ-018 done SHALL be 1 exactly in FINISH and FAIL.
REQ-019 On start, done, timeout, id_ok and ts_ok SHALL clear in the next cycle.
REQ-020 On start, id_value and ts_value SHALL keep their old contents until recaptured.
REQ-021 avm_read SHALL be 0 in IDLE, FINISH and FAIL.

Reset
REQ-022 While reset=1, all outputs SHALL be 0, the stall counter SHALL be 0, and the state SHALL be IDLE.
REQ-023 If reset asserts mid-read, avm_read SHALL drop asynchronously and no capture SHALL occur.

Configuration
REQ-024 The macro SYSID_CHECK_TIMESTAMP_EN SHALL select the timestamp read.
  Defined: behaviour is as in REQ-003 to REQ-021.
  Undefined: RD_TS SHALL be omitted, RD_ID SHALL complete to FINISH, ts_value SHALL be 0, and ts_ok SHALL be 1 whenever id_ok is valid.

Structure
REQ-025 A shared package system_0_sysid_pkg SHALL hold the FSM state enum, SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1 and the stall-counter width constant.
REQ-026 A sub-module system_0_sysid_stall_timer SHALL implement the stall counter and the timeout compare.

Verification
REQ-027 The bench SHALL cover the following directed scenarios, each as stimulus -> required response:
  Zero-wait slave returning ID=0 and TS=1763570452 -> done at cycle 3 after reset release, id_ok=1, ts_ok=1, timeout=0.
  Slave returning TS=32'h12345678 -> ts_ok=0, id_ok=1, ts_value=32'h12345678.
  waitrequest held 3 cycles on each read -> avm_address and avm_read stable throughout, done at cycle 9, both ok flags 1.
  waitrequest stuck at 1, TIMEOUT_CYCLES=4 -> FAIL with timeout=1 and done=1; avm_read=0 afterwards.
  Reset pulse during RD_TS -> all outputs 0; after release, a full re-check passes.
  Macro undefined -> only address 0 is read, done at cycle 2, ts_ok=1.
